keypad_scan_fifo: RTL and testbench



---
 rtl/keypad_scan_fifo_if.sv | 33 +++
 rtl/keypad_scan_fifo.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_fifo_if.sv
// Key-event handshake between the keypad scanner (master) and its consumer
// (slave): valid/ready head of the event FIFO plus flush and FIFO status.
interface keypad_scan_fifo_if #(
  parameter int CW    = 4,
  parameter int DEPTH = 4
);
  localparam int NW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          key_valid;
  logic          key_ready;
  logic [CW-1:0] key_code;
  logic [NW-1:0] fifo_count;
  logic          overflow;

  modport master (
    input  flush,
    input  key_ready,
    output key_valid,
    output key_code,
    output fifo_count,
    output overflow
  );

  modport slave (
    output flush,
    output key_ready,
    input  key_valid,
    input  key_code,
    input  fifo_count,
    input  overflow
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: drives active-low columns, samples active-low rows
// once per column slot, debounces whole scan frames (multi-key frames count as
// empty) and queues one event per debounced press in a small FIFO.
// row_i is expected to come from already-synchronised pins.
module keypad_scan_fifo #(
  parameter int NROWS      = 4,
  parameter int NCOLS      = 4,
  parameter int SCAN_TICKS = 100_000,
  parameter int SETTLE     = 10,
  parameter int DEBOUNCE   = 4,
  parameter int DEPTH      = 4,
  parameter int HEX_LEGEND = 1,
  localparam int NKEYS     = NROWS * NCOLS,
  localparam int IW        = (NKEYS > 1) ? $clog2(NKEYS) : 1,
  localparam int CW        = (IW > 4) ? IW : 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NROWS-1:0]    row_i,
  output logic [NCOLS-1:0]    col_o,
  keypad_scan_fifo_if.master  kif,
  output logic                key_held_o,
  output logic [CW-1:0]       held_code_o,
  output logic                multi_press_o
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int SW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam bit USE_LEGEND = (HEX_LEGEND == 1) && (NROWS == 4) && (NCOLS == 4);
  localparam bit DEB_ONE    = (DEBOUNCE == 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0] SETTLE_T  = TW'(SETTLE);
  localparam logic [SW-1:0] COL_LAST  = SW'(NCOLS - 1);
  localparam logic [DW-1:0] DEB_T     = DW'(DEBOUNCE);
  localparam logic [NW-1:0] FULL_N    = NW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  // Active-low one-hot column drive: column c pulls col[NCOLS-1-c] low.
  function automatic logic [NCOLS-1:0] col_decode(input logic [SW-1:0] sel);
    logic [NCOLS-1:0] v;
    v = '1;
    for (int c = 0; c < NCOLS; c++) begin
      if (sel == SW'(c)) begin
        v[NCOLS-1-c] = 1'b0;
      end else begin
        v[NCOLS-1-c] = v[NCOLS-1-c];
      end
    end
    return v;
  endfunction

  // Raw index (c*NROWS + r) to reported code; hex legend only on a 4x4 pad.
  function automatic logic [CW-1:0] key_to_code(input logic [IW-1:0] idx);
    logic [CW-1:0] wide;
    logic [CW-1:0] code;
    wide = CW'(idx);
    if (USE_LEGEND) begin
      case (wide[3:0])
        4'd0:    code = CW'(4'h1);
        4'd1:    code = CW'(4'h4);
        4'd2:    code = CW'(4'h7);
        4'd3:    code = CW'(4'h0);
        4'd4:    code = CW'(4'h2);
        4'd5:    code = CW'(4'h5);
        4'd6:    code = CW'(4'h8);
        4'd7:    code = CW'(4'hF);
        4'd8:    code = CW'(4'h3);
        4'd9:    code = CW'(4'h6);
        4'd10:   code = CW'(4'h9);
        4'd11:   code = CW'(4'hE);
        4'd12:   code = CW'(4'hA);
        4'd13:   code = CW'(4'hB);
        4'd14:   code = CW'(4'hC);
        4'd15:   code = CW'(4'hD);
        default: code = '0;
      endcase
    end else begin
      code = wide;
    end
    return code;
  endfunction

  // ---------------- scan timing ----------------
  logic [TW-1:0]    timer_q, timer_d;
  logic [SW-1:0]    col_sel_q, col_sel_d;
  logic [NCOLS-1:0] col_q;

  // Next slot timer value and column advance on timer wrap.
  always_comb begin
    timer_d   = timer_q;
    col_sel_d = col_sel_q;
    if (timer_q == TICK_LAST) begin
      timer_d = '0;
      if (col_sel_q == COL_LAST) begin
        col_sel_d = '0;
      end else begin
        col_sel_d = col_sel_q + SW'(1);
      end
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Slot timer, column select and registered column drive move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      col_sel_q <= '0;
      col_q     <= col_decode(SW'(0));
    end else begin
      timer_q   <= timer_d;
      col_sel_q <= col_sel_d;
      col_q     <= col_decode(col_sel_d);
    end
  end

  // ---------------- row sampling and frame accumulation ----------------
  logic          sample_s, frame_end_s, frame_key_s;
  logic [1:0]    slot_cnt_s, base_cnt_s, merged_cnt_s;
  logic [2:0]    sum_s;
  logic [IW-1:0] slot_idx_s, base_idx_s, merged_idx_s;
  logic [CW-1:0] frame_code_s;
  logic [1:0]    acc_cnt_q;
  logic [IW-1:0] acc_idx_q;
  logic          multi_q;

  // Count pressed rows in this column (saturating at 2) and merge into the frame.
  always_comb begin
    slot_cnt_s = 2'd0;
    slot_idx_s = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (!row_i[NROWS-1-r]) begin
        if (slot_cnt_s == 2'd0) begin
          slot_idx_s = IW'(int'(col_sel_q) * NROWS + r);
        end else begin
          slot_idx_s = slot_idx_s;
        end
        if (slot_cnt_s != 2'd2) begin
          slot_cnt_s = slot_cnt_s + 2'd1;
        end else begin
          slot_cnt_s = slot_cnt_s;
        end
      end else begin
        slot_cnt_s = slot_cnt_s;
      end
    end
    sample_s     = (timer_q == SETTLE_T);
    base_cnt_s   = (col_sel_q == '0) ? 2'd0 : acc_cnt_q;
    base_idx_s   = (col_sel_q == '0) ? '0 : acc_idx_q;
    sum_s        = {1'b0, base_cnt_s} + {1'b0, slot_cnt_s};
    merged_cnt_s = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
    merged_idx_s = (base_cnt_s != 2'd0) ? base_idx_s : slot_idx_s;
    frame_end_s  = sample_s && (col_sel_q == COL_LAST);
    frame_key_s  = frame_end_s && (merged_cnt_s == 2'd1);
    frame_code_s = key_to_code(merged_idx_s);
  end

  // Frame accumulator updated at each column's sample point; multi-key pulse at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q <= 2'd0;
      acc_idx_q <= '0;
      multi_q   <= 1'b0;
    end else begin
      multi_q <= frame_end_s && (merged_cnt_s == 2'd2);
      if (sample_s) begin
        acc_cnt_q <= merged_cnt_s;
        acc_idx_q <= merged_idx_s;
      end else begin
        acc_cnt_q <= acc_cnt_q;
        acc_idx_q <= acc_idx_q;
      end
    end
  end

  // ---------------- debounce FSM ----------------
  state_e        state_q;
  logic [IW-1:0] cand_q;
  logic [DW-1:0] cnt_q;
  logic          push_q, rel_q;
  logic [CW-1:0] push_code_q;

  // Frame-rate debounce: press after DEBOUNCE equal frames, release after DEBOUNCE empty ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      push_code_q <= '0;
      rel_q       <= 1'b0;
    end else begin
      push_q <= 1'b0;
      rel_q  <= 1'b0;
      if (frame_end_s) begin
        case (state_q)
          ST_IDLE, ST_CAND: begin
            if (frame_key_s && (state_q == ST_CAND) && (merged_idx_s == cand_q)) begin
              if ((cnt_q + DW'(1)) == DEB_T) begin
                push_q      <= 1'b1;
                push_code_q <= frame_code_s;
                cnt_q       <= '0;
                state_q     <= ST_HELD;
              end else begin
                cnt_q <= cnt_q + DW'(1);
              end
            end else if (frame_key_s) begin
              cand_q <= merged_idx_s;
              if (DEB_ONE) begin
                push_q      <= 1'b1;
                push_code_q <= frame_code_s;
                cnt_q       <= '0;
                state_q     <= ST_HELD;
              end else begin
                cnt_q   <= DW'(1);
                state_q <= ST_CAND;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (frame_key_s) begin
              cnt_q <= '0;
            end else if ((cnt_q + DW'(1)) == DEB_T) begin
              rel_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + DW'(1);
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  logic          held_q;
  logic [CW-1:0] held_code_q;

  // Held status follows the push/release strobes so it rises together with key_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q      <= 1'b0;
      held_code_q <= '0;
    end else if (push_q) begin
      held_q      <= 1'b1;
      held_code_q <= push_code_q;
    end else if (rel_q) begin
      held_q      <= 1'b0;
      held_code_q <= '0;
    end else begin
      held_q      <= held_q;
      held_code_q <= held_code_q;
    end
  end

  // ---------------- event FIFO ----------------
  logic [CW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          key_valid_q;
  logic [CW-1:0] key_code_q, head_d;
  logic          pop_s, full_s, wr_s, wr_en_s, drop_s;

  // FIFO next state; flush overrides any same-cycle push or pop.
  always_comb begin
    pop_s      = key_valid_q && kif.key_ready;
    full_s     = (count_q == FULL_N);
    wr_s       = push_q && (!full_s || pop_s);
    drop_s     = push_q && full_s && !pop_s;
    wr_en_s    = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (kif.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      wr_en_s    = wr_s;
      wr_ptr_d   = wr_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d   = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      count_d    = count_q + NW'(wr_s) - NW'(pop_s);
      overflow_d = overflow_q || drop_s;
    end
    if (count_d == '0) begin
      head_d = '0;
    end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_code_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= push_code_q;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and registered head outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      key_valid_q <= (count_d != '0);
      key_code_q  <= head_d;
    end
  end

  assign col_o          = col_q;
  assign kif.key_valid  = key_valid_q;
  assign kif.key_code   = key_code_q;
  assign kif.fifo_count = count_q;
  assign kif.overflow   = overflow_q;
  assign key_held_o     = held_q;
  assign held_code_o    = held_code_q;
  assign multi_press_o  = multi_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Self-checking bench for keypad_scan_fifo: a keypad model answers the column
// drive, a scoreboard queue holds the expected key codes, and table-driven
// presses plus hand-written sequences cover debounce, multi-key and FIFO cases.
module tb_keypad_scan_fifo;
  localparam int ST    = 20;
  localparam int SETL  = 2;
  localparam int DEB   = 3;
  localparam int DEP   = 4;
  localparam int FRAME = 4 * ST;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] press_mask = 16'h0000;
  logic [3:0]  row0, row1, col0, col1;
  logic        held0, held1, multi0, multi1;
  logic [3:0]  hcode0, hcode1;
  int          cyc;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  sb [$];

  typedef struct {
    int         idx;
    logic [3:0] code;
  } vec_t;
  vec_t vecs [6];

  keypad_scan_fifo_if #(.CW(4), .DEPTH(DEP)) kif0 ();
  keypad_scan_fifo_if #(.CW(4), .DEPTH(DEP)) kif1 ();

  keypad_scan_fifo #(.NROWS(4), .NCOLS(4), .SCAN_TICKS(ST), .SETTLE(SETL), .DEBOUNCE(DEB),
                     .DEPTH(DEP), .HEX_LEGEND(1)) dut (
    .clk(clk), .rst(rst), .row_i(row0), .col_o(col0), .kif(kif0),
    .key_held_o(held0), .held_code_o(hcode0), .multi_press_o(multi0));

  keypad_scan_fifo #(.NROWS(4), .NCOLS(4), .SCAN_TICKS(ST), .SETTLE(SETL), .DEBOUNCE(DEB),
                     .DEPTH(DEP), .HEX_LEGEND(0)) dut_raw (
    .clk(clk), .rst(rst), .row_i(row1), .col_o(col1), .kif(kif1),
    .key_held_o(held1), .held_code_o(hcode1), .multi_press_o(multi1));

  always #5 clk = ~clk;

  // Pressed key (c*4+r) shorts column c to row r: row[3-r] low while col[3-c] low.
  function automatic logic [3:0] keypad(input logic [3:0] col, input logic [15:0] mask);
    logic [3:0] rv;
    rv = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[3-c] && mask[c*4+r]) rv[3-r] = 1'b0;
    return rv;
  endfunction

  assign row0 = keypad(col0, press_mask);
  assign row1 = keypad(col1, press_mask);

  // Cycle index since the last reset edge (0 = first cycle out of reset).
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic goto_phase(input int ph);
    do step(); while ((cyc % FRAME) != ph);
  endtask

  task automatic set_ready(input logic v);
    kif0.key_ready = v;
    kif1.key_ready = v;
  endtask

  task automatic set_flush(input logic v);
    kif0.flush = v;
    kif1.flush = v;
  endtask

  // Press one key for on_f frames, release for off_f frames (changes land between frames).
  task automatic press_key(input int idx, input logic [3:0] code, input bit store,
                           input int on_f, input int off_f);
    int base;
    goto_phase(70);
    base = cyc;
    press_mask = 16'(1) << idx;
    if (store) sb.push_back(code);
    step_to(base + on_f * FRAME);
    check("held_while_pressed", held0, 1'b1);
    check("held_code", hcode0, code);
    press_mask = 16'h0000;
    step_to(base + (on_f + off_f) * FRAME);
    check("held_after_release", held0, 1'b0);
  endtask

  // Pop n entries through the handshake, comparing each head against the scoreboard.
  task automatic drain(input int n);
    int         waited;
    logic [3:0] exp;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (!kif0.key_valid && waited < 20) begin
        step();
        waited++;
      end
      check("drain_valid", kif0.key_valid, 1'b1);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_scoreboard: got entry, expected none queued");
        exp = 4'h0;
      end else begin
        exp = sb.pop_front();
      end
      check("drain_code", kif0.key_code, exp);
      step();
      check("drain_code_stable", kif0.key_code, exp);
      set_ready(1'b1);
      step();
      set_ready(1'b0);
    end
  endtask

  initial begin
    int base;
    int pulses;
    int pulses_raw;
    int held_seen;

    vecs[0] = '{idx: 2,  code: 4'h7};
    vecs[1] = '{idx: 6,  code: 4'h8};
    vecs[2] = '{idx: 10, code: 4'h9};
    vecs[3] = '{idx: 12, code: 4'hA};
    vecs[4] = '{idx: 13, code: 4'hB};
    vecs[5] = '{idx: 14, code: 4'hC};

    set_ready(1'b0);
    set_flush(1'b0);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", col0, 4'b0111);
    check("rst_key_valid", kif0.key_valid, 1'b0);
    check("rst_key_code", kif0.key_code, 4'h0);
    check("rst_fifo_count", kif0.fifo_count, 3'd0);
    check("rst_overflow", kif0.overflow, 1'b0);
    check("rst_key_held", held0, 1'b0);
    check("rst_held_code", hcode0, 4'h0);
    check("rst_multi", multi0, 1'b0);
    rst = 1'b0;
    step_to(19);
    check("col_slot0_end", col0, 4'b0111);
    step_to(20);
    check("col_slot1", col0, 4'b1011);

    // Clean press of key 5, held 5 frames
    goto_phase(70);
    base = cyc;
    press_mask = 16'(1) << 5;
    sb.push_back(4'h5);
    step_to(base + 233);
    check("clean_valid_before", kif0.key_valid, 1'b0);
    check("clean_held_before", held0, 1'b0);
    step_to(base + 234);
    check("clean_valid_rise", kif0.key_valid, 1'b1);
    check("clean_held_rise", held0, 1'b1);
    check("clean_code", kif0.key_code, 4'h5);
    check("clean_held_code", hcode0, 4'h5);
    check("clean_raw_code", kif1.key_code, 4'h5);
    check("clean_raw_held", held1, 1'b1);
    check("clean_raw_held_code", hcode1, 4'h5);
    step_to(base + 5 * FRAME);
    press_mask = 16'h0000;
    step_to(base + 633);
    check("clean_held_late", held0, 1'b1);
    step_to(base + 634);
    check("clean_held_fall", held0, 1'b0);
    check("clean_one_entry", kif0.fifo_count, 3'd1);
    drain(1);

    // Bounce on key F: 2 frames on, 1 off, 3 on
    goto_phase(70);
    base = cyc;
    press_mask = 16'(1) << 7;
    sb.push_back(4'hF);
    step_to(base + 2 * FRAME);
    press_mask = 16'h0000;
    step_to(base + 3 * FRAME);
    press_mask = 16'(1) << 7;
    step_to(base + 473);
    check("bounce_no_early_push", kif0.fifo_count, 3'd0);
    step_to(base + 474);
    check("bounce_valid", kif0.key_valid, 1'b1);
    check("bounce_code", kif0.key_code, 4'hF);
    step_to(base + 6 * FRAME);
    press_mask = 16'h0000;
    step_to(base + 10 * FRAME);
    check("bounce_single_event", kif0.fifo_count, 3'd1);
    drain(1);

    // Multi-key: keys 1 and 2 together for 4 frames
    goto_phase(70);
    base = cyc;
    press_mask = (16'(1) << 0) | (16'(1) << 4);
    pulses = 0;
    pulses_raw = 0;
    held_seen = 0;
    while (cyc < base + 4 * FRAME) begin
      step();
      if (multi0) pulses++;
      if (multi1) pulses_raw++;
      if (held0) held_seen++;
    end
    check("multi_pulses", pulses, 4);
    check("multi_pulses_raw", pulses_raw, 4);
    check("multi_no_held", held_seen, 0);
    check("multi_no_event", kif0.fifo_count, 3'd0);
    press_mask = 16'h0000;
    step_to(base + 8 * FRAME);

    // Overflow and order from the table, consumer stalled
    for (int i = 0; i < 6; i++)
      press_key(vecs[i].idx, vecs[i].code, sb.size() < DEP, 4, 4);
    check("ovf_count", kif0.fifo_count, 3'd4);
    check("ovf_flag", kif0.overflow, 1'b1);
    check("ovf_flag_raw", kif1.overflow, 1'b1);
    drain(4);
    check("ovf_sticky", kif0.overflow, 1'b1);
    set_flush(1'b1);
    step();
    set_flush(1'b0);
    check("flush_count", kif0.fifo_count, 3'd0);
    check("flush_overflow", kif0.overflow, 1'b0);
    check("flush_valid", kif0.key_valid, 1'b0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 4; i++)
      press_key(vecs[i].idx, vecs[i].code, 1'b1, 4, 4);
    check("full_count", kif0.fifo_count, 3'd4);
    goto_phase(70);
    base = cyc;
    press_mask = 16'(1) << vecs[4].idx;
    sb.push_back(vecs[4].code);
    step_to(base + 233);
    check("pp_head", kif0.key_code, sb.pop_front());
    set_ready(1'b1);
    step();
    set_ready(1'b0);
    check("pp_count", kif0.fifo_count, 3'd4);
    check("pp_count_raw", kif1.fifo_count, 3'd4);
    check("pp_overflow", kif0.overflow, 1'b0);
    step_to(base + 4 * FRAME);
    press_mask = 16'h0000;
    step_to(base + 8 * FRAME);
    drain(4);
    check("pp_empty", kif0.fifo_count, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
